// File: rtl/imul_issue_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imul_issue_arb
// Purpose  : Round-robin issue arbiter for a shared multiplier. Short ops are
//            tracked by a tag shadow pipeline, and long (decimal/table) ops by
//            a busy counter. Both feed a single registered writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module imul_issue_arb #(
  parameter int NREQ    = 3,
  parameter int TAG_W   = 9,
  parameter int LAT     = 3,
  parameter int DEC_LAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*13-1:0]    req_op,
  input  logic [NREQ*3-1:0]     req_rmode,
  input  logic [NREQ*4-1:0]     req_attr,
  input  logic [NREQ-1:0]       req_long,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic                  wb_stall,
  input  logic                  flush,
  output logic                  mul_en,
  output logic                  mul_clkEn,
  output logic [12:0]           mul_op,
  output logic [2:0]            mul_rmode,
  output logic [3:0]            mul_attr,
  output logic [1:0]            mul_sel,
  output logic                  wb_valid,
  output logic [TAG_W-1:0]      wb_tag,
  output logic                  wb_long,
  output logic                  busy
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] DEC_BUSY = 1'b1;

  localparam int               CNT_W    = (DEC_LAT > 2) ? $clog2(DEC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEC_LAT - 1);
  // All shadow stages except the last one; the last stage drains at any
  // non-stalled edge, so a long op may issue alongside that drain.
  localparam logic [LAT-1:0]   EARLY_MASK = {LAT{1'b1}} >> 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] dec_tag;
  logic [1:0]       rr;
  logic [LAT-1:0]   sh_vld;
  logic [TAG_W-1:0] sh_tag [LAT];

  logic             dec_done;
  logic             allow;
  logic             long_ok;
  logic [3:0]       elig;
  logic             found;
  logic [1:0]       gnt_idx;
  logic [1:0]       rr_nxt;
  logic             hs;
  int               cand;
  logic [12:0]      sel_op;
  logic [2:0]       sel_rmode;
  logic [3:0]       sel_attr;
  logic             sel_long;
  logic [TAG_W-1:0] sel_tag;

  // Global grant qualification: long unit finishing, stall, flush, reset.
  always_comb begin
    dec_done = (state == DEC_BUSY) && (cnt == '0) && !wb_stall;
    allow    = rst && !wb_stall && !flush && ((state == RUN) || dec_done);
    long_ok  = ~|(sh_vld & EARLY_MASK);
  end

  // Per-requester eligibility; long ops skip while short ops are in flight.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_vld[i] && (!req_long[i] || long_ok);
    end
  end

  // Round-robin search starting at rr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && elig[2'(cand)]) begin
        found   = 1'b1;
        gnt_idx = 2'(cand);
      end
    end
  end

  // One-hot grant and operand mux for the winning requester.
  always_comb begin
    req_rdy   = '0;
    sel_op    = '0;
    sel_rmode = '0;
    sel_attr  = '0;
    sel_long  = 1'b0;
    sel_tag   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        req_rdy[i] = allow && found;
        sel_op     = req_op[i*13 +: 13];
        sel_rmode  = req_rmode[i*3 +: 3];
        sel_attr   = req_attr[i*4 +: 4];
        sel_long   = req_long[i];
        sel_tag    = req_tag[i*TAG_W +: TAG_W];
      end
    end
    hs     = |req_rdy;
    rr_nxt = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  assign mul_clkEn = ~wb_stall;
  assign busy      = (|sh_vld) || (state == DEC_BUSY);

  // Round-robin pointer moves past the granted requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rr <= '0;
    else if (hs) rr <= rr_nxt;
  end

  // Multiplier issue registers; enable pulses once per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_en    <= 1'b0;
      mul_op    <= '0;
      mul_rmode <= '0;
      mul_attr  <= '0;
      mul_sel   <= '0;
    end else begin
      mul_en <= hs;
      if (hs) begin
        mul_op    <= sel_op;
        mul_rmode <= sel_rmode;
        mul_attr  <= sel_attr;
        mul_sel   <= gnt_idx;
      end
    end
  end

  // Short-op shadow pipeline, frozen by writeback stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_vld <= '0;
      for (int s = 0; s < LAT; s++) sh_tag[s] <= '0;
    end else if (flush) begin
      sh_vld <= '0;
    end else if (!wb_stall) begin
      sh_vld[0] <= hs && !sel_long;
      sh_tag[0] <= sel_tag;
      for (int s = 1; s < LAT; s++) begin
        sh_vld[s] <= sh_vld[s-1];
        sh_tag[s] <= sh_tag[s-1];
      end
    end
  end

  // Long-unit state machine and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      cnt     <= '0;
      dec_tag <= '0;
    end else if (flush) begin
      state <= RUN;
      cnt   <= '0;
    end else if (hs && sel_long) begin
      state   <= DEC_BUSY;
      cnt     <= CNT_LOAD;
      dec_tag <= sel_tag;
    end else if ((state == DEC_BUSY) && !wb_stall) begin
      if (cnt == '0) state <= RUN;
      else           cnt   <= cnt - 1'b1;
    end
  end

  // Writeback register merging short and long completions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_long  <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_long  <= 1'b0;
    end else if (!wb_stall) begin
      wb_valid <= sh_vld[LAT-1] || dec_done;
      wb_long  <= dec_done;
      if (dec_done)           wb_tag <= dec_tag;
      else if (sh_vld[LAT-1]) wb_tag <= sh_tag[LAT-1];
      else                    wb_tag <= '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/imul_issue_arb.md
IMUL_ISSUE_ARB -- requirements
Module: imul_issue_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 3, number of issue requesters (2..4).
- TAG_W, 9, result tag width.
- LAT, 3, short-op latency, issue edge to writeback, in cycles.
- DEC_LAT, 8, long-op (decimal/table unit) latency in cycles; SHALL exceed LAT.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on its rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- req_vld, in, NREQ, per-requester op valid.
- req_rdy, out, NREQ, per-requester grant; one-hot or zero.
- req_op, in, NREQ*13, opcode per requester.
- req_rmode, in, NREQ*3, rounding/mode bits per requester.
- req_attr, in, NREQ*4, attribute bits per requester.
- req_long, in, NREQ, op uses the long-latency unit.
- req_tag, in, NREQ*TAG_W, destination tag per requester.
- wb_stall, in, 1, writeback back-pressure; freezes the multiplier.
- flush, in, 1, kill all in-flight ops.
- mul_en, out, 1, multiplier enable.
- mul_clkEn, out, 1, multiplier pipeline clock enable.
- mul_op, out, 13, opcode to multiplier.
- mul_rmode, out, 3, mode to multiplier.
- mul_attr, out, 4, attributes to multiplier.
- mul_sel, out, 2, operand-mux select: index of the issued requester.
- wb_valid, out, 1, result valid this cycle.
- wb_tag, out, TAG_W, tag of the result.
- wb_long, out, 1, result comes from the long unit.
- busy, out, 1, long op in flight or any short op in flight.

Function
REQ-003 A handshake SHALL complete at an edge where req_vld[i] and req_rdy[i] are both high; req_rdy SHALL be combinational from registered state and req_vld.
- REQ-004 Arbitration: round-robin. Pointer rr starts at 0. Search order is rr, rr+1, ..., wrapping modulo NREQ. After a grant to i, rr SHALL become (i+1) mod NREQ; rr SHALL hold when nothing is granted.
- REQ-005 No grant SHALL occur while wb_stall=1, flush=1, or state=DEC_BUSY.
- REQ-006 Grant of a long op SHALL require the short shadow pipeline to be empty, or to empty at the same edge; otherwise that requester is skipped and the search continues.
- REQ-007 mul_en, mul_op, mul_rmode, mul_attr and mul_sel SHALL be registered from the granted requester in the cycle after the handshake edge. mul_en SHALL be 1 for exactly one cycle per issue.
- REQ-008 mul_clkEn SHALL equal ~wb_stall.
- REQ-009 Short-op shadow pipeline: LAT stages of {valid, tag}, advanced only when wb_stall=0.
  - wb_valid=1 and wb_tag=the issued tag SHALL appear LAT cycles after the handshake edge, provided there is no stall.
  - Each stall cycle SHALL add one cycle to that latency.
- REQ-010 State machine has two states, RUN and DEC_BUSY.
  - RUN to DEC_BUSY on a long-op handshake; the counter loads DEC_LAT-1.
  - In DEC_BUSY the counter decrements each non-stalled cycle.
  - At 0: wb_valid=1, wb_long=1, wb_tag=the stored tag for one cycle, then the state returns to RUN.
  - A new grant is allowed at the edge that leaves DEC_BUSY.
- REQ-011 Short and long writebacks SHALL never coincide (guaranteed by REQ-005/006).
- REQ-012 flush SHALL clear all shadow valid bits and force RUN. wb_valid SHALL be 0 from the next cycle until a new op completes. flush has priority over a simultaneous handshake, which does not complete.
- REQ-013 busy SHALL be the OR of all shadow valid bits and (state==DEC_BUSY).
- REQ-014 wb_tag and wb_long SHALL be 0 whenever wb_valid=0.

Reset
- REQ-015 While rst=0, asynchronously:
  - state=RUN, rr=0, counter=0, all shadow valid bits 0.
  - mul_en=0, mul_op=0, mul_rmode=0, mul_attr=0, mul_sel=0.
  - wb_valid=0, wb_tag=0, wb_long=0, busy=0, req_rdy=0.
- REQ-016 Reset asserted mid-operation SHALL discard all in-flight ops with no writeback. The first grant is possible at the first edge after deassertion.

Verification
- REQ-017 Round-robin: req_vld=3'b111 held with NREQ=3 -> grants are 0,1,2,0,1,2 on consecutive edges, with mul_sel following one cycle later.
- REQ-018 Latency: a single short op, tag 0x05, handshaked at edge E -> mul_en=1 after E; wb_valid=1 with wb_tag=0x05 after edge E+3 only.
- REQ-019 Stall: a short op is issued, then wb_stall=1 for 2 cycles during flight -> mul_clkEn=0 for those cycles and wb_valid appears 5 cycles after the handshake; no grant occurs while stalled.
- REQ-020 Long op:
  - Short op (tag 1) at E, then long op (tag 2) requested at E+1 -> the long op waits until the short shadow pipeline drains.
  - wb tag 1 at E+3; the long op is granted at E+3; wb tag 2 with wb_long=1 at E+11.
  - Other requesters get no grant until DEC_BUSY exits.
- REQ-021 Flush:
  - Two short ops in flight, flush=1 together with req_vld -> no wb_valid for either op, no grant that cycle, busy=0 next cycle.
  - rst pulsed low during DEC_BUSY -> all outputs 0 immediately, no writeback afterwards.
